imuldiv_muldiv_issue: RTL
=========================

// Module: imuldiv_muldiv_issue
// PURPOSE
//  Front-end issue/merge stage for the iterative integer mul and div units.
//  Accepts one muldiv request (fn, a, b) and routes it to the mul or div unit.
//  Captures the selected WIDTH-bit slice of that unit's 2*WIDTH result.
//  Returns it on a single val/rdy response port. Exactly one op is in flight at a time.
// PARAMETERS
//  WIDTH  32  operand/result width; unit results are 2*WIDTH
// PORTS
//  clk                    in   1        clock; all logic on posedge
//  reset                  in   1        synchronous, active-low (0 = reset)
//  muldivreq_msg_fn       in   3        op code, encodings in imuldiv_pkg
//  muldivreq_msg_a        in   WIDTH    operand a
//  muldivreq_msg_b        in   WIDTH    operand b
//  muldivreq_val/_rdy     in/out 1      request handshake
//  muldivresp_msg_result  out  WIDTH    selected result slice
//  muldivresp_val/_rdy    out/in 1      response handshake
//  mulreq_msg_a/_b        out  WIDTH    to mul unit (signed multiply)
//  mulreq_val/_rdy        out/in 1      mul request handshake
//  mulresp_msg_result     in   2*WIDTH  from mul unit
//  mulresp_val/_rdy       in/out 1      mul response handshake
//  divreq_msg_fn          out  1        1 = signed, 0 = unsigned
//  divreq_msg_a/_b        out  WIDTH    to div unit
//  divreq_val/_rdy        out/in 1      div request handshake
//  divresp_msg_result     in   2*WIDTH  {rem, quot} from div unit
//  divresp_val/_rdy       in/out 1      div response handshake
// BEHAVIOUR
//  - fn codes: 0 MUL (mul[W-1:0]), 1 MULH (mul[2W-1:W]), 2 DIV / 3 DIVU (div[W-1:0]),
//    4 REM / 5 REMU (div[2W-1:W]). Codes 6 and 7 are illegal.
//  - FSM:
//    IDLE  : muldivreq_rdy=1. On go, latch fn/a/b -> ISSUE; illegal fn -> RESP with result 0.
//    ISSUE : drive mulreq_val or divreq_val (chosen by fn) from latched regs.
//            Unit handshake -> WAIT. If unit rdy=0, stay; operands stay stable.
//    WAIT  : assert resp_rdy only to the selected unit. On its val, capture slice -> RESP.
//    RESP  : muldivresp_val=1, result held stable. On rdy -> IDLE.
//  - muldivreq_rdy is 0 outside IDLE: one-cycle bubble between back-to-back ops.
//  - Latency: accept at cycle 0; unit req handshake at cycle 1 at the earliest;
//    muldivresp_val rises the cycle after the unit response handshake.
//  - A response from the non-selected unit is never accepted (its rdy stays 0).
//  - divreq_msg_fn = 1 for DIV/REM, 0 for DIVU/REMU.
//  - Reset (reset==0 at posedge): state->IDLE, result reg->0, latched fn/a/b->0.
//    While reset is low, every val/rdy output is 0.
//  - Reset mid-op aborts the op. Units share this reset, so no stale response survives.
// CONFIGURATION
//  IMULDIV_ZERO_FASTPATH_EN defined: in IDLE, an accepted op skips ISSUE/WAIT
//  and goes directly to RESP (response 1 cycle after accept) when:
//    MUL/MULH with a==0 or b==0  -> 0
//    DIV/DIVU with b==0          -> all-ones
//    REM/REMU with b==0          -> a
//  Not defined: every legal op goes through its unit. Div-by-zero result is
//  whatever the div unit returns.
// STRUCTURE
//  - imuldiv_pkg: fn encodings, FSM state encodings, result-slice select enum.
//  - Sub-module imuldiv_muldiv_issue_dpath holds the operand/fn regs, result reg,
//    slice mux and fast-path zero detect.
//  - Top holds the FSM and handshake logic.
// TESTING
//  - MUL a=7, b=-3; mul unit returns 64'hFFFF_FFFF_FFFF_FFEB
//    -> mulreq a=7, b=-3; result 32'hFFFF_FFEB.
//  - MULH a=32'h8000_0000, b=2; unit returns 64'hFFFF_FFFF_0000_0000 -> result 32'hFFFF_FFFF.
//  - REMU a=17, b=5; div unit returns {2,3}, divreq_msg_fn=0 -> result 2.
//    divresp presented 10 cycles late -> still result 2; mulresp_rdy stays 0 throughout.
//  - DIV issued with divreq_rdy low for 4 cycles -> divreq_val high, operands stable;
//    muldivreq_rdy=0; resp_rdy held low 3 cycles -> result held.
//  - fn=6 -> no unit request; result 0 one cycle after accept.
//    Reset pulsed during WAIT -> all val low, back in IDLE.
//  - With IMULDIV_ZERO_FASTPATH_EN: DIV a=9, b=0 -> 32'hFFFF_FFFF, no divreq_val.
//    Without it: divreq_val asserted.

Source files
------------

// File: rtl/imuldiv_pkg.sv
// Shared encodings for the muldiv issue stage: op codes, FSM states and result-slice selection.
// Small decode helpers keep the op-code meaning in one place.
package imuldiv_pkg;

    localparam logic [2:0] FN_MUL  = 3'd0;
    localparam logic [2:0] FN_MULH = 3'd1;
    localparam logic [2:0] FN_DIV  = 3'd2;
    localparam logic [2:0] FN_DIVU = 3'd3;
    localparam logic [2:0] FN_REM  = 3'd4;
    localparam logic [2:0] FN_REMU = 3'd5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        SLICE_MUL_LO = 2'd0,
        SLICE_MUL_HI = 2'd1,
        SLICE_DIV_LO = 2'd2,
        SLICE_DIV_HI = 2'd3
    } slice_sel_e;

    function automatic logic fn_legal(input logic [2:0] fn);
        logic ok;
        case (fn)
            FN_MUL, FN_MULH, FN_DIV, FN_DIVU, FN_REM, FN_REMU: ok = 1'b1;
            default:                                          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic fn_is_div(input logic [2:0] fn);
        logic d;
        case (fn)
            FN_DIV, FN_DIVU, FN_REM, FN_REMU: d = 1'b1;
            default:                          d = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic fn_div_signed(input logic [2:0] fn);
        logic s;
        case (fn)
            FN_DIV, FN_REM: s = 1'b1;
            default:        s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic slice_sel_e fn_slice(input logic [2:0] fn);
        slice_sel_e sel;
        case (fn)
            FN_MUL:          sel = SLICE_MUL_LO;
            FN_MULH:         sel = SLICE_MUL_HI;
            FN_DIV, FN_DIVU: sel = SLICE_DIV_LO;
            FN_REM, FN_REMU: sel = SLICE_DIV_HI;
            default:         sel = SLICE_MUL_LO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/imuldiv_muldiv_issue_dpath.sv
// Datapath for the muldiv issue stage: latched fn/operands, result register and slice mux.
// Optional zero fast path enabled by defining IMULDIV_ZERO_FASTPATH_EN.
module imuldiv_muldiv_issue_dpath
    import imuldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 capture,
    input  logic [2:0]           fn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   mul_result,
    input  logic [2*WIDTH-1:0]   div_result,
    output logic [2:0]           fn_r,
    output logic [WIDTH-1:0]     a_r,
    output logic [WIDTH-1:0]     b_r,
    output logic [WIDTH-1:0]     result_r,
    output logic                 fast_hit_s
);

    logic [WIDTH-1:0] fast_val_s;
    logic [WIDTH-1:0] slice_s;

`ifdef IMULDIV_ZERO_FASTPATH_EN
    // Zero-operand detect on the incoming request, resolved without a unit round trip.
    always_comb begin
        fast_hit_s = 1'b0;
        fast_val_s = {WIDTH{1'b0}};
        case (fn)
            FN_MUL, FN_MULH: begin
                if ((a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}})) begin
                    fast_hit_s = 1'b1;
                end else begin
                    fast_hit_s = 1'b0;
                end
            end
            FN_DIV, FN_DIVU: begin
                if (b == {WIDTH{1'b0}}) begin
                    fast_hit_s = 1'b1;
                    fast_val_s = {WIDTH{1'b1}};
                end else begin
                    fast_hit_s = 1'b0;
                end
            end
            FN_REM, FN_REMU: begin
                if (b == {WIDTH{1'b0}}) begin
                    fast_hit_s = 1'b1;
                    fast_val_s = a;
                end else begin
                    fast_hit_s = 1'b0;
                end
            end
            default: begin
                fast_hit_s = 1'b0;
                fast_val_s = {WIDTH{1'b0}};
            end
        endcase
    end
`else
    assign fast_hit_s = 1'b0;
    assign fast_val_s = {WIDTH{1'b0}};
`endif

    // Pick the WIDTH-bit half of the selected unit's result.
    always_comb begin
        slice_s = {WIDTH{1'b0}};
        case (fn_slice(fn_r))
            SLICE_MUL_LO: slice_s = mul_result[WIDTH-1:0];
            SLICE_MUL_HI: slice_s = mul_result[2*WIDTH-1:WIDTH];
            SLICE_DIV_LO: slice_s = div_result[WIDTH-1:0];
            SLICE_DIV_HI: slice_s = div_result[2*WIDTH-1:WIDTH];
            default:      slice_s = {WIDTH{1'b0}};
        endcase
    end

    // Request latch: operands stay stable for the whole op.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fn_r <= 3'd0;
            a_r  <= {WIDTH{1'b0}};
            b_r  <= {WIDTH{1'b0}};
        end else if (load) begin
            fn_r <= fn;
            a_r  <= a;
            b_r  <= b;
        end else begin
            fn_r <= fn_r;
            a_r  <= a_r;
            b_r  <= b_r;
        end
    end

    // Result register: immediate value for illegal/fast ops, unit slice otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            result_r <= {WIDTH{1'b0}};
        end else if (load) begin
            if (!fn_legal(fn)) begin
                result_r <= {WIDTH{1'b0}};
            end else if (fast_hit_s) begin
                result_r <= fast_val_s;
            end else begin
                result_r <= result_r;
            end
        end else if (capture) begin
            result_r <= slice_s;
        end else begin
            result_r <= result_r;
        end
    end

endmodule

// File: rtl/imuldiv_muldiv_issue.sv
// Muldiv issue/merge stage: routes one request to the mul or div unit and returns the chosen slice.
// Optional feature macro: IMULDIV_ZERO_FASTPATH_EN (handled in the datapath).
module imuldiv_muldiv_issue
    import imuldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           muldivreq_msg_fn,
    input  logic [WIDTH-1:0]     muldivreq_msg_a,
    input  logic [WIDTH-1:0]     muldivreq_msg_b,
    input  logic                 muldivreq_val,
    output logic                 muldivreq_rdy,
    output logic [WIDTH-1:0]     muldivresp_msg_result,
    output logic                 muldivresp_val,
    input  logic                 muldivresp_rdy,
    output logic [WIDTH-1:0]     mulreq_msg_a,
    output logic [WIDTH-1:0]     mulreq_msg_b,
    output logic                 mulreq_val,
    input  logic                 mulreq_rdy,
    input  logic [2*WIDTH-1:0]   mulresp_msg_result,
    input  logic                 mulresp_val,
    output logic                 mulresp_rdy,
    output logic                 divreq_msg_fn,
    output logic [WIDTH-1:0]     divreq_msg_a,
    output logic [WIDTH-1:0]     divreq_msg_b,
    output logic                 divreq_val,
    input  logic                 divreq_rdy,
    input  logic [2*WIDTH-1:0]   divresp_msg_result,
    input  logic                 divresp_val,
    output logic                 divresp_rdy
);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [2:0]       fn_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             fast_hit_s;
    logic             is_div_s;
    logic             go_s;
    logic             unit_req_fire_s;
    logic             unit_resp_fire_s;

    imuldiv_muldiv_issue_dpath #(.WIDTH(WIDTH)) u_dpath (
        .clk        (clk),
        .reset      (reset),
        .load       (go_s),
        .capture    (unit_resp_fire_s),
        .fn         (muldivreq_msg_fn),
        .a          (muldivreq_msg_a),
        .b          (muldivreq_msg_b),
        .mul_result (mulresp_msg_result),
        .div_result (divresp_msg_result),
        .fn_r       (fn_r),
        .a_r        (a_r),
        .b_r        (b_r),
        .result_r   (muldivresp_msg_result),
        .fast_hit_s (fast_hit_s)
    );

    assign is_div_s = fn_is_div(fn_r);

    // Handshake outputs decode from the state register; reset low forces them all off.
    assign muldivreq_rdy  = reset && (state_r == ST_IDLE);
    assign mulreq_val     = reset && (state_r == ST_ISSUE) && !is_div_s;
    assign divreq_val     = reset && (state_r == ST_ISSUE) &&  is_div_s;
    assign mulresp_rdy    = reset && (state_r == ST_WAIT)  && !is_div_s;
    assign divresp_rdy    = reset && (state_r == ST_WAIT)  &&  is_div_s;
    assign muldivresp_val = reset && (state_r == ST_RESP);

    assign mulreq_msg_a  = a_r;
    assign mulreq_msg_b  = b_r;
    assign divreq_msg_a  = a_r;
    assign divreq_msg_b  = b_r;
    assign divreq_msg_fn = fn_div_signed(fn_r);

    assign go_s             = muldivreq_val && muldivreq_rdy;
    assign unit_req_fire_s  = (mulreq_val && mulreq_rdy) || (divreq_val && divreq_rdy);
    assign unit_resp_fire_s = (mulresp_val && mulresp_rdy) || (divresp_val && divresp_rdy);

    // Next-state logic for the single-op-in-flight sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (go_s) begin
                    if (!fn_legal(muldivreq_msg_fn) || fast_hit_s) begin
                        state_nxt_s = ST_RESP;
                    end else begin
                        state_nxt_s = ST_ISSUE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (unit_req_fire_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (unit_resp_fire_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (muldivresp_val && muldivresp_rdy) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

endmodule
